// File: rtl/s38417_lane_check.sv
// Lane-check stage: sweeps slots 0..2 of a 13x3 bank against a latched expected vector and commits a sticky verdict.
// Optional LANE_CHECK_MASK_EN adds mask_data, which removes masked lanes from the verdict (lane 0 mask beats lane0_en).
module s38417_lane_check #(
  parameter int LANES = 13,
  parameter int SLOTS = 3
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             load_valid,
  input  logic [3:0]       load_lane,
  input  logic [1:0]       load_slot,
  input  logic             load_data,
  input  logic             start,
  input  logic [LANES-1:0] exp_data,
  input  logic             lane0_en,
  input  logic             commit_en,
`ifdef LANE_CHECK_MASK_EN
  input  logic [LANES-1:0] mask_data,
`endif
  output logic [SLOTS-1:0] slot_sel,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [3:0]       fail_lane,
  output logic             res_q
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_slot;
  logic [SLOTS-1:0] r_slot_sel;
  logic [SLOTS-1:0] r_bank [LANES];
  logic [LANES-1:0] r_exp;
  logic             r_lane0_en;
  logic             r_sticky;
  logic [3:0]       r_fail_lane;
  logic             r_res;
  logic             w_accept, w_busy, w_done;
  logic [LANES-1:0] w_mism;
  logic [3:0]       w_low;
`ifdef LANE_CHECK_MASK_EN
  logic [LANES-1:0] r_mask;
`endif

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        w_busy = 1'b1;
        if (r_slot == 2'(SLOTS - 1)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_busy      = 1'b1;
        w_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Compare reads registered bank contents, so a same-cycle write is seen only by later sweeps.
  always_comb begin
    w_mism = '0;
    for (int l = 0; l < LANES; l++) w_mism[l] = r_bank[l][r_slot] ^ r_exp[l];
    if (!r_lane0_en) w_mism[0] = 1'b1;
`ifdef LANE_CHECK_MASK_EN
    w_mism = w_mism & ~r_mask;
`endif
    w_low = 4'd15;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (w_mism[l]) w_low = 4'(l);
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      for (int l = 0; l < LANES; l++) r_bank[l] <= '0;
    end else if (load_valid && (load_lane < 4'(LANES)) && (load_slot < 2'(SLOTS))) begin
      r_bank[load_lane][load_slot] <= load_data;
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_slot      <= '0;
      r_slot_sel  <= '0;
      r_exp       <= '0;
      r_lane0_en  <= 1'b0;
      r_sticky    <= 1'b0;
      r_fail_lane <= 4'd15;
      r_res       <= 1'b0;
`ifdef LANE_CHECK_MASK_EN
      r_mask      <= '0;
`endif
    end else if (w_accept) begin
      r_slot      <= '0;
      r_slot_sel  <= {{(SLOTS-1){1'b0}}, 1'b1};
      r_exp       <= exp_data;
      r_lane0_en  <= lane0_en;
      r_sticky    <= 1'b0;
      r_fail_lane <= 4'd15;
`ifdef LANE_CHECK_MASK_EN
      r_mask      <= mask_data;
`endif
    end else if (r_state == S_SWEEP) begin
      r_sticky <= r_sticky | (|w_mism);
      if (w_low < r_fail_lane) r_fail_lane <= w_low;
      if (r_slot == 2'(SLOTS - 1)) begin
        r_slot     <= '0;
        r_slot_sel <= '0;
      end else begin
        r_slot     <= r_slot + 2'd1;
        r_slot_sel <= r_slot_sel << 1;
      end
    end else if ((r_state == S_DONE) && commit_en) begin
      r_res <= r_sticky;
    end
  end

  assign slot_sel  = r_slot_sel;
  assign busy      = w_busy;
  assign done      = w_done;
  assign fail      = r_sticky;
  assign fail_lane = r_fail_lane;
  assign res_q     = r_res;

endmodule

// File: tb/tb_s38417_lane_check.sv
// Directed plus randomized bench for s38417_lane_check; verdicts come from a per-lane reference model over a 13x3 bank image.
module tb_s38417_lane_check;

  logic        CK, RN, load_valid, load_data, start, lane0_en, commit_en;
  logic [3:0]  load_lane;
  logic [1:0]  load_slot;
  logic [12:0] exp_data, mask_data;
  logic [2:0]  slot_sel;
  logic        busy, done, fail, res_q;
  logic [3:0]  fail_lane;

  int tests = 0;
  int errs  = 0;

  logic [2:0] m_bank [13];
  logic       m_res;

  s38417_lane_check dut (
    .CK(CK), .RN(RN), .load_valid(load_valid), .load_lane(load_lane), .load_slot(load_slot),
    .load_data(load_data), .start(start), .exp_data(exp_data), .lane0_en(lane0_en),
    .commit_en(commit_en),
`ifdef LANE_CHECK_MASK_EN
    .mask_data(mask_data),
`endif
    .slot_sel(slot_sel), .busy(busy), .done(done), .fail(fail), .fail_lane(fail_lane), .res_q(res_q)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  // A lane fails if any of its three slots differs from its expected bit, or lane 0 is disabled; masked lanes never fail.
  task automatic model(input logic [12:0] e, input logic l0, input logic [12:0] mk,
                       output logic f, output logic [3:0] fl);
    f  = 1'b0;
    fl = 4'd15;
    for (int l = 0; l < 13; l++) begin
      logic bad;
      bad = (m_bank[l] != {3{e[l]}}) || (l == 0 && !l0);
`ifdef LANE_CHECK_MASK_EN
      if (mk[l]) bad = 1'b0;
`endif
      if (bad) begin
        f = 1'b1;
        if (fl == 4'd15) fl = 4'(l);
      end
    end
  endtask

  task automatic wr(input int lane, input int slot, input logic d);
    load_valid = 1'b1;
    load_lane  = 4'(lane);
    load_slot  = 2'(slot);
    load_data  = d;
    @(posedge CK); #1;
    load_valid = 1'b0;
    if (lane < 13 && slot < 3) m_bank[lane][slot] = d;
  endtask

  // Runs one sweep from IDLE; an optional write is issued during the slot-1 compare cycle.
  task automatic sweep(input logic [12:0] e, input logic l0, input logic cm, input logic [12:0] mk,
                       input int wl, input int ws, input logic wd);
    logic       f;
    logic [3:0] fl;
    model(e, l0, mk, f, fl);
    exp_data = e; lane0_en = l0; commit_en = cm; mask_data = mk; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0; exp_data = 13'($urandom); lane0_en = 1'($urandom); mask_data = 13'($urandom);
    chk("sel_slot0", 16'(slot_sel), 16'h1);
    chk("busy_sweep", 16'(busy), 16'h1);
    chk("no_done_sweep", 16'(done), 16'h0);
    @(posedge CK); #1;
    chk("sel_slot1", 16'(slot_sel), 16'h2);
    if (wl >= 0) begin
      load_valid = 1'b1; load_lane = 4'(wl); load_slot = 2'(ws); load_data = wd;
    end
    @(posedge CK); #1;
    if (wl >= 0) begin
      load_valid = 1'b0;
      if (wl < 13 && ws < 3) m_bank[wl][ws] = wd;
    end
    chk("sel_slot2", 16'(slot_sel), 16'h4);
    @(posedge CK); #1;
    chk("done_pulse", 16'(done), 16'h1);
    chk("sel_done", 16'(slot_sel), 16'h0);
    chk("fail", 16'(fail), 16'(f));
    chk("fail_lane", 16'(fail_lane), 16'(fl));
    if (cm) m_res = f;
    @(posedge CK); #1;
    chk("done_clear", 16'(done), 16'h0);
    chk("busy_idle", 16'(busy), 16'h0);
    chk("res_q", 16'(res_q), 16'(m_res));
    chk("fail_stable", 16'(fail_lane), 16'(fl));
  endtask

  initial begin
    int pulses;
    RN = 1'b0; load_valid = 1'b0; load_lane = '0; load_slot = '0; load_data = 1'b0;
    start = 1'b0; exp_data = '0; lane0_en = 1'b0; commit_en = 1'b0; mask_data = '0;
    m_res = 1'b0;
    for (int l = 0; l < 13; l++) m_bank[l] = '0;
    #12;
    chk("rst_sel", 16'(slot_sel), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_fail", 16'(fail), 16'h0);
    chk("rst_fail_lane", 16'(fail_lane), 16'hf);
    chk("rst_res", 16'(res_q), 16'h0);
    @(posedge CK); #1;
    RN = 1'b1;
    @(posedge CK); #1;

    sweep(13'h0, 1'b1, 1'b1, 13'h0, -1, 0, 1'b0);
    wr(5, 1, 1'b1);
    sweep(13'h0, 1'b1, 1'b1, 13'h0, -1, 0, 1'b0);
    wr(5, 1, 1'b0);
    sweep(13'h0, 1'b0, 1'b0, 13'h0, -1, 0, 1'b0);

    // Continuous start: a new sweep may only begin after DONE returns to IDLE.
    commit_en = 1'b0; lane0_en = 1'b1; exp_data = '0; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge CK); #1;
      chk("held_start_done", 16'(done), 16'((i % 5) == 3));
      if (done) pulses++;
    end
    start = 1'b0;
    chk("held_start_pulses", 16'(pulses), 16'd3);
    @(posedge CK); #1;

    sweep(13'h0, 1'b1, 1'b1, 13'h0, 2, 1, 1'b1);
    sweep(13'h0, 1'b1, 1'b1, 13'h0, -1, 0, 1'b0);

    // Reset in the middle of a sweep clears everything immediately.
    exp_data = '0; lane0_en = 1'b1; commit_en = 1'b1; start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    @(posedge CK); #1;
    chk("mid_sel_slot1", 16'(slot_sel), 16'h2);
    RN = 1'b0;
    #1;
    chk("mid_rst_sel", 16'(slot_sel), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    chk("mid_rst_done", 16'(done), 16'h0);
    chk("mid_rst_fail", 16'(fail), 16'h0);
    chk("mid_rst_fail_lane", 16'(fail_lane), 16'hf);
    chk("mid_rst_res", 16'(res_q), 16'h0);
    m_res = 1'b0;
    for (int l = 0; l < 13; l++) m_bank[l] = '0;
    @(posedge CK); #1;
    @(posedge CK); #1;
    chk("held_rst_done", 16'(done), 16'h0);
    RN = 1'b1;
    @(posedge CK); #1;
    sweep(13'h0, 1'b1, 1'b1, 13'h0, -1, 0, 1'b0);

`ifdef LANE_CHECK_MASK_EN
    wr(5, 1, 1'b1);
    sweep(13'h0, 1'b1, 1'b1, 13'h20, -1, 0, 1'b0);
    sweep(13'h0, 1'b0, 1'b1, 13'h21, -1, 0, 1'b0);
    wr(5, 1, 1'b0);
`endif

    for (int it = 0; it < 12; it++) begin
      logic [12:0] e, mk;
      for (int k = 0; k < 3; k++) wr($urandom_range(0, 15), $urandom_range(0, 3), 1'($urandom));
      for (int l = 0; l < 13; l++) e[l] = m_bank[l][0] ^ ($urandom_range(0, 9) == 0);
`ifdef LANE_CHECK_MASK_EN
      mk = 13'($urandom) & 13'($urandom);
`else
      mk = '0;
`endif
      sweep(e, ($urandom_range(0, 3) != 0), 1'($urandom), mk, -1, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
